// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, LCD command codes and the long-execution classifier.
package lcd_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} lcd_state_t;
    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME = 8'h02;
    // 0x03 is the second encoding of return-home and needs the same long delay
    function automatic logic is_long_exec(input logic rs, input logic nib, input logic [7:0] b);
        return !rs && !nib && (b == LCD_CLEAR || b == LCD_HOME || b == 8'h03);
    endfunction
endpackage

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: 2-way round-robin pick with optional burst lock (LCD_ARB_LOCK_EN).
module lcd_rr_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       idle,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_lock,
    output logic [1:0] req_ready,
    output logic       sel
);
    logic last;
    logic accept;
`ifdef LCD_ARB_LOCK_EN
    logic locked;
    logic owner;
    always_comb sel = locked ? owner : (&req_valid ? ~last : req_valid[1]);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    always_comb sel = &req_valid ? ~last : req_valid[1];
`endif
    always_comb req_ready = (idle && !RST && req_valid[sel]) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign accept = |(req_valid & req_ready);
    always_ff @(posedge CLK) begin
        if (RST) begin
            last <= 1'b1;
`ifdef LCD_ARB_LOCK_EN
            locked <= 1'b0;
            owner <= 1'b0;
`endif
        end else if (accept) begin
            last <= sel;
`ifdef LCD_ARB_LOCK_EN
            locked <= req_lock[sel];
            owner <= sel;
`endif
        end
    end
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares a 4-bit HD44780 bus between two byte requesters.
// Optional burst locking is enabled by defining LCD_ARB_LOCK_EN.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int E_HIGH_CYC = 2,
    parameter int EXEC_CYC = 50,
    parameter int LONG_EXEC_CYC = 2000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_nib,
    input  logic [1:0] req_rs,
    input  logic [7:0] req_byte0,
    input  logic [7:0] req_byte1,
    input  logic [1:0] req_lock,
    output logic [1:0] req_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       RS,
    output logic       E,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7
);
    localparam int MAX_A = LONG_EXEC_CYC > E_HIGH_CYC ? LONG_EXEC_CYC : E_HIGH_CYC;
    localparam int MAX_C = MAX_A > SETUP_CYC ? MAX_A : SETUP_CYC;
    localparam int CW = $clog2(MAX_C + 1);
    lcd_state_t state;
    logic [CW-1:0] cnt;
    logic hi;
    logic nib_q;
    logic [7:0] byte_q;
    logic [3:0] d_q;
    logic sel;
    logic accept;
    logic [7:0] byte_in;
    lcd_rr_arbiter u_arb (
        .CLK(CLK),
        .RST(RST),
        .idle(state == ST_IDLE),
        .req_valid(req_valid),
        .req_lock(req_lock),
        .req_ready(req_ready),
        .sel(sel)
    );
    assign accept = |(req_valid & req_ready);
    assign byte_in = sel ? req_byte1 : req_byte0;
    assign {D7, D6, D5, D4} = d_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt <= '0;
            hi <= 1'b0;
            nib_q <= 1'b0;
            byte_q <= '0;
            d_q <= '0;
            grant_id <= 1'b0;
            busy <= 1'b0;
            E <= 1'b0;
            RS <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state <= ST_SETUP;
                    cnt <= CW'(SETUP_CYC - 1);
                    hi <= ~req_nib[sel];
                    nib_q <= req_nib[sel];
                    byte_q <= byte_in;
                    RS <= req_rs[sel];
                    d_q <= req_nib[sel] ? byte_in[3:0] : byte_in[7:4];
                    grant_id <= sel;
                    busy <= 1'b1;
                end
                ST_SETUP: if (cnt == '0) begin
                    state <= ST_PULSE;
                    cnt <= CW'(E_HIGH_CYC - 1);
                    E <= 1'b1;
                end else cnt <= cnt - 1'b1;
                ST_PULSE: if (cnt == '0) begin
                    state <= ST_HOLD;
                    E <= 1'b0;
                end else cnt <= cnt - 1'b1;
                // data only changes after the hold cycle, never while E is high or falling
                ST_HOLD: if (hi) begin
                    state <= ST_SETUP;
                    hi <= 1'b0;
                    d_q <= byte_q[3:0];
                    cnt <= CW'(SETUP_CYC - 1);
                end else begin
                    state <= ST_WAIT;
                    cnt <= is_long_exec(RS, nib_q, byte_q) ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
                end
                ST_WAIT: if (cnt == '0) begin
                    state <= ST_IDLE;
                    busy <= 1'b0;
                end else cnt <= cnt - 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single HD44780-style 4-bit LCD bus (RS, E, D7..D4) between two byte-level requesters, e.g. a boot/init sequencer and a text streamer. Each accepted request is serialised into one or two nibble writes with generated E strobes, then a post-write execution delay before the bus is released. Arbitration is round-robin per transfer, with optional burst locking. Sits between the requester logic and the LCD pins.

## Interface
- SETUP_CYC, 1: cycles RS/D are stable before E rises (≥1)
- E_HIGH_CYC, 2: cycles E is high per nibble (≥1)
- EXEC_CYC, 50: post-transfer wait for normal writes (≥1)
- LONG_EXEC_CYC, 2000: post-transfer wait for clear/home commands (≥ EXEC_CYC)

- CLK  in  1  clock; everything on rising edge
- RST  in  1  reset; synchronous, active-high
- req_valid  in  2  request valid, bit i = requester i
- req_nib  in  2  1 = single-nibble transfer (byte[3:0] only)
- req_rs  in  2  RS value for the transfer
- req_byte0 / req_byte1  in  8 each  payload of requester 0 / 1
- req_lock  in  2  burst lock request (used only under LCD_ARB_LOCK_EN)
- req_ready  out  2  accept strobe; transfer happens when valid & ready
- busy  out  1  high from the cycle after accept until return to IDLE
- grant_id  out  1  index of the requester currently being served
- RS, E, D4, D5, D6, D7  out  1 each  LCD bus

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT; `hi` flag selects the nibble being sent.
- IDLE: round-robin pick among valid requesters. With both valid, the one not granted last wins. After reset, requester 0 wins the first tie. req_ready is combinational: high only in IDLE for the selected index, and at most one bit is set.
- On accept: latch rs, byte, nib and grant_id. Two-nibble transfers start with hi=1 (byte[7:4]); single-nibble transfers start with hi=0 (byte[3:0]). Go to SETUP.
- SETUP: drive RS and the current nibble with E=0 for SETUP_CYC cycles, then go to PULSE.
- PULSE: E=1 for E_HIGH_CYC cycles, then go to HOLD.
- HOLD: E=0 for one cycle with data unchanged. If hi=1, clear hi and return to SETUP; otherwise go to WAIT.
- WAIT: bus idle with E=0 and data held. Length is LONG_EXEC_CYC if rs=0, nib=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise EXEC_CYC. Then go to IDLE.
- Requests dropped while not ready are never served. There is no queueing.
- A single down-counter is shared by all timed states. Its width is clog2(max(LONG_EXEC_CYC, E_HIGH_CYC, SETUP_CYC)+1).

## Timing
- Reset values: E=0, RS=0, D7..D4=0, req_ready=0 during reset, busy=0, grant_id=0. State is IDLE and the last-grant pointer is 1.
- RST mid-transfer aborts immediately. E is low on the next cycle and no further strobes occur.
- Accept at cycle t: SETUP begins at t+1, and E first rises at t+1+SETUP_CYC.
- Two-nibble transfer: IDLE is re-entered 2·(SETUP_CYC+E_HIGH_CYC+1)+wait cycles after t+1. With defaults and a normal write this is 58 cycles.
- Single-nibble transfer: SETUP_CYC+E_HIGH_CYC+1+wait cycles after t+1.
- Earliest next accept is the first IDLE cycle, so transfers run back-to-back with no bubble.
- RS and D never change while E=1 or in the cycle E falls.

## Configuration
- LCD_ARB_LOCK_EN defined:
  - If the accepted requester has req_lock high, the next IDLE grants only that requester. The other requester gets ready=0 even if the owner is not valid.
  - The lock releases on accepting a transfer from the owner with req_lock low.
  - RST clears the lock.
- Undefined: req_lock is ignored and pure per-transfer round-robin applies.

## Structure
- Package lcd_pkg holds:
  - the state enum
  - command constants LCD_CLEAR=8'h01, LCD_HOME=8'h02
  - the function that classifies a long-execution command
- Sub-module lcd_rr_arbiter holds the 2-way round-robin pick, the last-grant pointer and lock logic. It produces req_ready and the grant index.

## Test plan
- Req0 only, rs=1, byte=0x48, defaults -> E pulses twice, each 2 cycles high. D=0x4 on the first pulse, D=0x8 on the second, RS=1 throughout; IDLE 58 cycles after t+1.
- Both valid continuously after reset -> grants alternate 0,1,0,1. Each accept occurs in the first IDLE cycle after the previous WAIT.
- Req1, rs=0, byte=0x01 -> WAIT lasts 2000 cycles. Same transfer with byte=0x0C waits 50 cycles.
- req_nib=1, byte=0x03 -> exactly one E pulse with D=0x3. IDLE after 1+2+1+50 cycles.
- RST asserted during PULSE -> E=0 next cycle and all outputs at reset values. First post-reset tie goes to requester 0.
- LCD_ARB_LOCK_EN: req0 sends 3 bytes with lock=1,1,0 while req1 is continuously valid -> req1 is served only after req0's third byte.
